preg_freelist: RTL

- Physical-register free list for rename: the allocating end of the preg lifecycle whose busy/ready state the busy table tracks.
- Hands out up to two free pregs per cycle to rename.
- Accepts up to two released pregs per cycle from commit.
- Restores the speculative head to the committed head on a pipeline flush.
- alloc_preg0/1 plus accepted-alloc strobes drive the busy table alloc ports.

---
 rtl/preg_freelist_pkg.sv | 20 ++
 rtl/freelist_ram.sv | 36 +++
 rtl/preg_freelist.sv | 94 +++++++++
 3 files changed

// File: rtl/preg_freelist_pkg.sv
// rtl/preg_freelist_pkg.sv - free list sizing constants and shared types
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif

package preg_freelist_pkg;

  localparam int PREG_COUNT   = 64;
  localparam int ARCH_COUNT   = 32;
  localparam int FL_DEPTH     = PREG_COUNT - ARCH_COUNT;
  localparam int PREG_WIDTH   = $clog2(PREG_COUNT);
  localparam int FL_IDX_WIDTH = $clog2(FL_DEPTH);
  // One extra bit so full and empty are distinguishable.
  localparam int FL_PTR_WIDTH = FL_IDX_WIDTH + 1;

  typedef logic [PREG_WIDTH-1:0]   preg_t;
  typedef logic [FL_IDX_WIDTH-1:0] fl_idx_t;
  typedef logic [FL_PTR_WIDTH-1:0] fl_ptr_t;

endpackage

// File: rtl/freelist_ram.sv
// rtl/freelist_ram.sv - ring storage, two combinational reads, two writes
module freelist_ram
  import preg_freelist_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  fl_idx_t rd_addr0,
  input  fl_idx_t rd_addr1,
  output preg_t   rd_data0,
  output preg_t   rd_data1,
  input  logic    wr_en0,
  input  fl_idx_t wr_addr0,
  input  preg_t   wr_data0,
  input  logic    wr_en1,
  input  fl_idx_t wr_addr1,
  input  preg_t   wr_data1
);

  preg_t ring [FL_DEPTH];

  assign rd_data0 = ring[rd_addr0];
  assign rd_data1 = ring[rd_addr1];

  // Reset seeds the ring with every non-architectural preg in order.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        ring[i] <= preg_t'(ARCH_COUNT + i);
      end
    end else begin
      if (wr_en0) ring[wr_addr0] <= wr_data0;
      if (wr_en1) ring[wr_addr1] <= wr_data1;
    end
  end

endmodule

// File: rtl/preg_freelist.sv
// rtl/preg_freelist.sv - rename physical-register free list
module preg_freelist
  import preg_freelist_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_req0,
  input  logic               alloc_req1,
  output logic [`PREG_RANGE] alloc_preg0,
  output logic [`PREG_RANGE] alloc_preg1,
  output logic               alloc_stall,
  output logic               alloc_fire0,
  output logic               alloc_fire1,
  input  logic               free_en0,
  input  logic [`PREG_RANGE] free_addr0,
  input  logic               free_en1,
  input  logic [`PREG_RANGE] free_addr1,
  input  logic               commit_en0,
  input  logic               commit_en1,
  input  logic               flush,
  output logic [5:0]         free_count,
  output logic               overflow_err
);

  fl_ptr_t    spec_head;
  fl_ptr_t    arch_head;
  fl_ptr_t    tail;
  fl_ptr_t    room;
  logic [1:0] n_req;
  logic [1:0] n_fire;
  logic [1:0] n_commit;
  logic [1:0] n_free;
  logic       accept0;
  logic       accept1;
  logic       drop;
  preg_t      rd_data0;
  preg_t      rd_data1;
  fl_idx_t    wr_addr1;

  assign n_req    = {1'b0, alloc_req0} + {1'b0, alloc_req1};
  assign n_commit = {1'b0, commit_en0} + {1'b0, commit_en1};

  assign free_count  = tail - spec_head;
  assign alloc_stall = (FL_PTR_WIDTH'(n_req) > free_count) && !flush;
  assign alloc_fire0 = alloc_req0 && !alloc_stall && !flush;
  assign alloc_fire1 = alloc_req1 && !alloc_stall && !flush;
  assign n_fire      = {1'b0, alloc_fire0} + {1'b0, alloc_fire1};

  // A lone slot-1 request takes the head entry rather than skipping one.
  assign alloc_preg0 = rd_data0;
  assign alloc_preg1 = (alloc_req1 && !alloc_req0) ? rd_data0 : rd_data1;

  // Frees beyond the remaining capacity are dropped and flagged.
  assign room    = fl_ptr_t'(FL_DEPTH) - free_count;
  assign accept0 = free_en0 && (room != '0);
  assign accept1 = free_en1 && (room > FL_PTR_WIDTH'(accept0));
  assign drop    = (free_en0 && !accept0) || (free_en1 && !accept1);
  assign n_free  = {1'b0, accept0} + {1'b0, accept1};
  assign wr_addr1 = tail[FL_IDX_WIDTH-1:0] + FL_IDX_WIDTH'(accept0);

  freelist_ram u_ram (
    .clock    (clock),
    .reset    (reset),
    .rd_addr0 (spec_head[FL_IDX_WIDTH-1:0]),
    .rd_addr1 (spec_head[FL_IDX_WIDTH-1:0] + FL_IDX_WIDTH'(1)),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .wr_en0   (accept0),
    .wr_addr0 (tail[FL_IDX_WIDTH-1:0]),
    .wr_data0 (free_addr0),
    .wr_en1   (accept1),
    .wr_addr1 (wr_addr1),
    .wr_data1 (free_addr1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_head    <= '0;
      arch_head    <= '0;
      tail         <= fl_ptr_t'(FL_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      arch_head <= arch_head + FL_PTR_WIDTH'(n_commit);
      tail      <= tail + FL_PTR_WIDTH'(n_free);
      if (flush) begin
        spec_head <= arch_head + FL_PTR_WIDTH'(n_commit);
      end else begin
        spec_head <= spec_head + FL_PTR_WIDTH'(n_fire);
      end
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule
